// File: rtl/player_sprite_fetch.sv
// rtl/player_sprite_fetch.sv - round-robin sprite row fetcher that streams ROM pixels to two requesters
//
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   req[1:0]                level row-fetch request per requester
//   row0, row1              requested sprite row for requester 0 / 1
//   ack[1:0], err           one-cycle grant pulse; err flags an out-of-range row
//   rom_player, rom_addr    ROM sprite select and read address
//   rom_data                ROM pixel, one cycle after the address
//   pix_valid, pix_id,      pixel strobe, owning requester, column and value
//   pix_col, pix_data
//   row_done                pulses with the last pixel of a row
//   busy                    high whenever a row is in flight

module player_sprite_fetch #(
    parameter int SPR_W  = 30,
    parameter int SPR_H  = 30,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [4:0]        row0,
    input  logic [4:0]        row1,
    output logic [1:0]        ack,
    output logic              err,
    output logic              rom_player,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              pix_valid,
    output logic              pix_id,
    output logic [4:0]        pix_col,
    output logic [3:0]        pix_data,
    output logic              row_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [4:0]        COL_LAST   = 5'(SPR_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SPR_W);

    state_t            state_q, state_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;
    logic              last_grant_q, last_grant_d;
    logic              rom_player_q, rom_player_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [4:0]        col_q, col_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_id_q, pix_id_d;
    logic [4:0]        pix_col_q, pix_col_d;
    logic              row_done_q, row_done_d;

    // Arbitration: with both requesters asking, the one not served last wins.
    logic              win;
    logic [4:0]        win_row;
    logic              win_bad_row;
    logic [ADDR_W-1:0] win_base;

    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ~last_grant_q;
        end else if (req[1]) begin
            win = 1'b1;
        end
        win_row     = win ? row1 : row0;
        win_bad_row = (int'(win_row) >= SPR_H);
        win_base    = ADDR_W'(win_row) * ROW_STRIDE;
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = 2'b00;
        err_d        = 1'b0;
        last_grant_d = last_grant_q;
        rom_player_d = rom_player_q;
        rom_addr_d   = rom_addr_q;
        col_d        = col_q;
        pix_valid_d  = 1'b0;
        pix_id_d     = pix_id_q;
        pix_col_d    = pix_col_q;
        row_done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    ack_d        = win ? 2'b10 : 2'b01;
                    last_grant_d = win;
                    if (win_bad_row) begin
                        // Error grants are acknowledged but never touch the ROM.
                        err_d = 1'b1;
                    end else begin
                        state_d      = FETCH;
                        rom_player_d = win;
                        rom_addr_d   = win_base;
                        col_d        = 5'd0;
                    end
                end
            end

            FETCH: begin
                // The pixel for the column issued now appears next cycle.
                pix_valid_d = 1'b1;
                pix_id_d    = rom_player_q;
                pix_col_d   = col_q;
                if (col_q == COL_LAST) begin
                    row_done_d = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    col_d      = col_q + 5'd1;
                end
            end

            DRAIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rom_player_q <= 1'b0;
            rom_addr_q   <= '0;
            col_q        <= 5'd0;
            pix_valid_q  <= 1'b0;
            pix_id_q     <= 1'b0;
            pix_col_q    <= 5'd0;
            row_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
            rom_player_q <= rom_player_d;
            rom_addr_q   <= rom_addr_d;
            col_q        <= col_d;
            pix_valid_q  <= pix_valid_d;
            pix_id_q     <= pix_id_d;
            pix_col_q    <= pix_col_d;
            row_done_q   <= row_done_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign rom_player = rom_player_q;
    assign rom_addr   = rom_addr_q;
    assign pix_valid  = pix_valid_q;
    assign pix_id     = pix_id_q;
    assign pix_col    = pix_col_q;
    assign pix_data   = rom_data;
    assign row_done   = row_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_player_sprite_fetch.sv
// tb/tb_player_sprite_fetch.sv - self-checking bench for player_sprite_fetch

module tb_player_sprite_fetch;

    localparam int SPR_W  = 30;
    localparam int SPR_H  = 30;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic [1:0]        req;
    logic [4:0]        row0;
    logic [4:0]        row1;
    logic [1:0]        ack;
    logic              err;
    logic              rom_player;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic              pix_valid;
    logic              pix_id;
    logic [4:0]        pix_col;
    logic [3:0]        pix_data;
    logic              row_done;
    logic              busy;

    player_sprite_fetch #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .req(req), .row0(row0), .row1(row1),
        .ack(ack), .err(err), .rom_player(rom_player), .rom_addr(rom_addr),
        .rom_data(rom_data), .pix_valid(pix_valid), .pix_id(pix_id),
        .pix_col(pix_col), .pix_data(pix_data), .row_done(row_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] rom_fn(input logic p, input int addr);
        logic [9:0] a;
        a = 10'(addr);
        return a[3:0] ^ a[7:4] ^ {a[9:8], 1'b0, p};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_player, int'(rom_addr));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    typedef struct {
        logic id;
        int   col;
        int   addr;
    } pix_t;

    pix_t exp_q[$];

    task automatic push_row(input logic id, input int row);
        for (int c = 0; c < SPR_W; c++) begin
            pix_t p;
            p.id = id; p.col = c; p.addr = row * SPR_W + c;
            exp_q.push_back(p);
        end
    endtask

    // Scoreboard: each pixel is matched against the address issued the cycle before.
    int   prev_addr = 0;
    logic prev_player = 1'b0;
    always @(negedge clk) begin
        if (pix_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", 1, 0);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                chk("pix_id", int'(pix_id), int'(e.id));
                chk("pix_col", int'(pix_col), e.col);
                chk("rom_addr_issued", prev_addr, e.addr);
                chk("rom_player_issued", int'(prev_player), int'(e.id));
                chk("pix_data", int'(pix_data), int'(rom_fn(e.id, e.addr)));
                chk("row_done", int'(row_done), (e.col == SPR_W - 1) ? 1 : 0);
            end
        end else if (row_done) begin
            chk("row_done_without_pixel", 1, 0);
        end
        prev_addr   = int'(rom_addr);
        prev_player = rom_player;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        if (busy) chk("idle_timeout", 1, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Drive one request from IDLE and check the grant cycle plus the cycle after.
    task automatic do_grant(input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [1:0] exp_ack, input logic exp_err);
        @(negedge clk);
        req = r; row0 = a0; row1 = a1;
        if (!exp_err) push_row(exp_ack[1], exp_ack[1] ? int'(a1) : int'(a0));
        @(negedge clk);
        chk("grant_ack", int'(ack), int'(exp_ack));
        chk("grant_err", int'(err), int'(exp_err));
        chk("grant_busy", int'(busy), exp_err ? 0 : 1);
        if (!exp_err) chk("grant_rom_player", int'(rom_player), int'(exp_ack[1]));
        req = 2'b00;
        @(negedge clk);
        chk("ack_one_cycle", int'(ack), 0);
        chk("err_one_cycle", int'(err), 0);
        if (exp_err) begin
            chk("err_no_busy", int'(busy), 0);
            chk("err_no_pixel", int'(pix_valid), 0);
        end
        wait_idle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_pix_valid"}, int'(pix_valid), 0);
        chk({tag, "_pix_col"}, int'(pix_col), 0);
        chk({tag, "_pix_id"}, int'(pix_id), 0);
        chk({tag, "_row_done"}, int'(row_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_rom_player"}, int'(rom_player), 0);
    endtask

    typedef struct {
        logic [1:0] req;
        logic [4:0] r0;
        logic [4:0] r1;
        logic [1:0] ack;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] rr_exp[3];
        int k;
        int n;

        // Grant history matters: the table starts with last_grant = 0.
        vecs[0] = '{2'b01, 5'd0,  5'd0,  2'b01, 1'b0};
        vecs[1] = '{2'b10, 5'd0,  5'd29, 2'b10, 1'b0};
        vecs[2] = '{2'b11, 5'd2,  5'd29, 2'b01, 1'b0};
        vecs[3] = '{2'b11, 5'd5,  5'd7,  2'b10, 1'b0};
        vecs[4] = '{2'b10, 5'd0,  5'd30, 2'b10, 1'b1};
        vecs[5] = '{2'b11, 5'd3,  5'd4,  2'b01, 1'b0};
        vecs[6] = '{2'b01, 5'd31, 5'd0,  2'b01, 1'b1};
        vecs[7] = '{2'b11, 5'd0,  5'd31, 2'b10, 1'b1};
        vecs[8] = '{2'b11, 5'd29, 5'd0,  2'b01, 1'b0};

        req = 2'b00; row0 = 5'd0; row1 = 5'd0;
        reset = 1'b1;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both requesters held from reset: 0, then 1, then 0 again.
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
        push_row(1'b0, 2); push_row(1'b1, 29); push_row(1'b0, 2);
        @(negedge clk);
        req = 2'b11; row0 = 5'd2; row1 = 5'd29;
        k = 0; n = 0;
        while (k < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (ack != 2'b00) begin
                chk("rr_ack", int'(ack), int'(rr_exp[k]));
                k++;
                if (k == 3) req = 2'b00;
            end
        end
        if (k < 3) begin
            chk("rr_timeout", 1, 0);
            req = 2'b00;
        end
        wait_idle();

        for (int i = 0; i < 9; i++) begin
            do_grant(vecs[i].req, vecs[i].r0, vecs[i].r1, vecs[i].ack, vecs[i].err);
        end

        // Request from requester 0 arrives mid-row of requester 1; it waits for IDLE.
        @(negedge clk);
        req = 2'b10; row1 = 5'd4;
        push_row(1'b1, 4);
        @(negedge clk);
        chk("mid_first_ack", int'(ack), 2);
        req = 2'b01; row0 = 5'd6;
        push_row(1'b0, 6);
        n = 0;
        k = 0;
        do begin
            @(negedge clk);
            n++;
            if (ack != 2'b00) k++;
        end while (busy && n < 60);
        chk("mid_no_early_ack", k, 0);
        chk("mid_reached_idle", int'(busy), 0);
        @(negedge clk);
        chk("mid_ack_after_drain", int'(ack), 1);
        req = 2'b00;
        wait_idle();

        // Reset while a row is streaming.
        @(negedge clk);
        req = 2'b01; row0 = 5'd1;
        for (int c = 0; c <= 10; c++) begin
            pix_t p;
            p.id = 1'b0; p.col = c; p.addr = SPR_W + c;
            exp_q.push_back(p);
        end
        @(negedge clk);
        req = 2'b00;
        n = 0;
        while (!(pix_valid && pix_col == 5'd10) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reached_col10", int'(pix_valid && pix_col == 5'd10), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_queue", exp_q.size(), 0);
        for (int c = 0; c < 4; c++) @(negedge clk);
        do_grant(2'b11, 5'd0, 5'd5, 2'b01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
